// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight destination tags in a
// private shift-register scoreboard and produces registered per-operand forward selects.
module fwd_scoreboard #(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int CW       = 16,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance_en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic                  id_regwr,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_is_load,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] ex_fwd_sel,
  output logic [DEPTH:0]        slot_valid,
  output logic [CW-1:0]         stall_count
);

  // Slot 0 is EX; valid reaches slot DEPTH only so it can be observed before it leaves.
  logic [DEPTH:0]        sbVld;
  logic [DEPTH-1:0]      sbRegwr;
  logic [DEPTH-1:0]      sbLoad;
  logic [AW-1:0]         sbRd [DEPTH];

  logic [NUM_SRC*SW-1:0] selNext;
  logic [NUM_SRC*SW-1:0] selReg_p1;
  logic [NUM_SRC-1:0]    opHaz;
  logic [CW-1:0]         stallCnt;
  logic                  idLive;
  logic                  idAdv;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ID stage: match each operand against slots, youngest match overriding older ones.
  always_comb begin
    selNext = '0;
    opHaz   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (id_src_used[i] && sbVld[s] && sbRegwr[s] && (sbRd[s] != '0) &&
            (sbRd[s] == id_src[i*AW +: AW])) begin
          selNext[i*SW +: SW] = SW'(s + 1);
          opHaz[i]            = sbLoad[s] && ((s + 1) < LOAD_LAT);
        end
      end
    end
  end

  assign idLive = id_valid & ~flush;
  assign stall  = idLive & (|opHaz);
  assign idAdv  = idLive & ~(|opHaz);

  // ID -> EX boundary: control state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbVld     <= '0;
      selReg_p1 <= '0;
      stallCnt  <= '0;
    end else if (advance_en) begin
      sbVld     <= {sbVld[DEPTH-1:0], idAdv};
      selReg_p1 <= idAdv ? selNext : '0;
      if (stall) stallCnt <= satInc(stallCnt);
    end
  end

  // Tag payload; meaningless whenever the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (advance_en) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sbRegwr[k] <= sbRegwr[k-1];
        sbLoad[k]  <= sbLoad[k-1];
        sbRd[k]    <= sbRd[k-1];
      end
      sbRegwr[0] <= id_regwr;
      sbLoad[0]  <= id_is_load;
      sbRd[0]    <= id_rd;
    end
  end

  assign ex_fwd_sel  = selReg_p1;
  assign slot_valid  = sbVld;
  assign stall_count = stallCnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: a default instance and a DEPTH=4/LOAD_LAT=3
// instance share stimulus; expectations are queued by the driver and checked by a monitor.
module tb_fwd_scoreboard;
  localparam int AW = 5;
  localparam int NS = 2;

  logic           clk = 1'b0;
  logic           reset, advance_en, flush, id_valid, id_regwr, id_is_load;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]  id_src_used;
  logic [AW-1:0]  id_rd;
  logic           stallA, stallB;
  logic [3:0]     selA;
  logic [5:0]     selB;
  logic [2:0]     svA;
  logic [4:0]     svB;
  logic [15:0]    cntA, cntB;

  always #5 clk = ~clk;

  fwd_scoreboard dutA (
    .clk(clk), .reset(reset), .advance_en(advance_en), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_regwr(id_regwr), .id_rd(id_rd), .id_is_load(id_is_load),
    .stall(stallA), .ex_fwd_sel(selA), .slot_valid(svA), .stall_count(cntA)
  );

  fwd_scoreboard #(.DEPTH(4), .LOAD_LAT(3)) dutB (
    .clk(clk), .reset(reset), .advance_en(advance_en), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_regwr(id_regwr), .id_rd(id_rd), .id_is_load(id_is_load),
    .stall(stallB), .ex_fwd_sel(selB), .slot_valid(svB), .stall_count(cntB)
  );

  // Negative expected value means "do not check this field".
  typedef struct {
    int dut;
    int st;
    int s0;
    int s1;
    int sv;
    int cnt;
  } exp_t;

  exp_t  q[$];
  string qNm[$];
  int    total = 0;
  int    bad   = 0;
  event  chkNow;
  exp_t  monE;
  string monNm;

  task automatic cmp(string nm, string fld, int act, int req);
    if (req >= 0) begin
      total++;
      if (act != req) begin
        bad++;
        $display("FAIL %s %s: actual=%0d required=%0d", nm, fld, act, req);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or chkNow);
      while (q.size() > 0) begin
        monE  = q.pop_front();
        monNm = qNm.pop_front();
        if (monE.dut == 0) begin
          cmp(monNm, "stall", int'(stallA), monE.st);
          cmp(monNm, "sel0", int'(selA[1:0]), monE.s0);
          cmp(monNm, "sel1", int'(selA[3:2]), monE.s1);
          cmp(monNm, "slot_valid", int'(svA), monE.sv);
          cmp(monNm, "stall_count", int'(cntA), monE.cnt);
        end else begin
          cmp(monNm, "stall", int'(stallB), monE.st);
          cmp(monNm, "sel0", int'(selB[2:0]), monE.s0);
          cmp(monNm, "sel1", int'(selB[5:3]), monE.s1);
          cmp(monNm, "slot_valid", int'(svB), monE.sv);
          cmp(monNm, "stall_count", int'(cntB), monE.cnt);
        end
      end
    end
  end

  task automatic push(int dut, string nm, int st, int s0, int s1, int sv, int cnt);
    exp_t r;
    r.dut = dut; r.st = st; r.s0 = s0; r.s1 = s1; r.sv = sv; r.cnt = cnt;
    q.push_back(r);
    qNm.push_back(nm);
  endtask

  task automatic setId(bit v, int s0, int s1, bit [1:0] used, bit wr, int rd, bit ld);
    id_valid    = v;
    id_src      = {AW'(s1), AW'(s0)};
    id_src_used = used;
    id_regwr    = wr;
    id_rd       = AW'(rd);
    id_is_load  = ld;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nxt();
    reset = 1'b1; flush = 1'b0; advance_en = 1'b1;
    setId(0, 0, 0, 2'b00, 0, 0, 0);
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; advance_en = 1'b1; flush = 1'b0;
    setId(0, 0, 0, 2'b00, 0, 0, 0);
    push(0, "reset", 0, 0, 0, 0, 0);
    push(1, "resetB", 0, 0, 0, 0, 0);
    nxt();
    reset = 1'b0;

    // ALU back-to-back
    nxt(); setId(1, 0, 0, 2'b00, 1, 8, 0);  push(0, "alu.add", 0, -1, -1, -1, -1);
    nxt(); setId(1, 8, 0, 2'b01, 1, 10, 0); push(0, "alu.sub", 0, -1, -1, -1, -1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "alu.ex", -1, 1, 0, 3'b011, 0);

    // Distance-two ALU
    doReset();
    nxt(); setId(1, 0, 0, 2'b00, 1, 8, 0);  push(0, "dist2.add", 0, -1, -1, -1, -1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "dist2.nop", 0, -1, -1, -1, -1);
    nxt(); setId(1, 3, 8, 2'b11, 1, 11, 0); push(0, "dist2.or", 0, -1, -1, -1, -1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "dist2.ex", -1, 0, 2, 3'b101, 0);

    // Load-use, default latency
    doReset();
    nxt(); setId(1, 4, 0, 2'b01, 1, 9, 1);  push(0, "lu.lw", 0, -1, -1, -1, 0);
    nxt(); setId(1, 9, 0, 2'b01, 1, 10, 0); push(0, "lu.stall", 1, 0, 0, 3'b001, 0);
    nxt();                                  push(0, "lu.release", 0, 0, 0, 3'b010, 1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "lu.ex", 0, 2, 0, 3'b101, 1);

    // Younger ALU write hides older load (checked on both load latencies)
    doReset();
    nxt(); setId(1, 4, 0, 2'b01, 1, 9, 1);  push(0, "prio.lw", 0, -1, -1, -1, -1);
    nxt(); setId(1, 4, 0, 2'b01, 1, 9, 0);  push(0, "prio.addi", 0, -1, -1, -1, -1);
    nxt(); setId(1, 9, 9, 2'b11, 1, 12, 0); push(0, "prio.use", 0, -1, -1, -1, -1);
                                            push(1, "prioB.use", 0, -1, -1, -1, -1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "prio.ex", -1, 1, 1, -1, 0);
                                            push(1, "prioB.ex", -1, 1, 1, -1, 0);

    // Register zero never matches
    doReset();
    nxt(); setId(1, 0, 0, 2'b00, 1, 0, 1);  push(0, "r0.lw", 0, -1, -1, -1, -1);
    nxt(); setId(1, 0, 0, 2'b11, 1, 13, 0); push(0, "r0.use", 0, -1, -1, -1, -1);
                                            push(1, "r0B.use", 0, -1, -1, -1, -1);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(0, "r0.ex", 0, 0, 0, -1, 0);
                                            push(1, "r0B.ex", 0, 0, 0, -1, 0);

    // Flush during a load-use hazard
    doReset();
    nxt(); setId(1, 4, 0, 2'b01, 1, 9, 1);  push(0, "flush.lw", 0, -1, -1, -1, -1);
    nxt(); setId(1, 9, 0, 2'b01, 1, 10, 0); flush = 1'b1; push(0, "flush.use", 0, -1, -1, -1, 0);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  flush = 1'b0; push(0, "flush.ex", 0, 0, 0, 3'b010, 0);

    // Freeze while stalled
    doReset();
    nxt(); setId(1, 0, 0, 2'b00, 1, 8, 0);  push(0, "frz.add", 0, -1, -1, -1, -1);
    nxt(); setId(1, 8, 0, 2'b01, 1, 9, 1);  push(0, "frz.lw", 0, -1, -1, -1, -1);
    nxt(); setId(1, 9, 0, 2'b01, 1, 14, 0); advance_en = 1'b0;
    push(0, "frz0", 1, 1, 0, 3'b011, 0);
    nxt(); push(0, "frz1", 1, 1, 0, 3'b011, 0);
    nxt(); push(0, "frz2", 1, 1, 0, 3'b011, 0);
    nxt(); advance_en = 1'b1; push(0, "frz3", 1, 1, 0, 3'b011, 0);
    nxt(); push(0, "frz.rel", 0, 0, 0, 3'b110, 1);

    // Deeper pipe, later load data
    doReset();
    nxt(); setId(1, 0, 0, 2'b00, 1, 5, 1);  push(1, "sw.lw", 0, -1, -1, -1, 0);
    nxt(); setId(1, 5, 0, 2'b01, 1, 15, 0); push(1, "sw.st1", 1, -1, -1, -1, 0);
    nxt(); push(1, "sw.st2", 1, -1, -1, -1, 1);
    nxt(); push(1, "sw.go", 0, -1, -1, -1, 2);
    nxt(); setId(0, 0, 0, 2'b00, 0, 0, 0);  push(1, "sw.ex", -1, 3, 0, 5'b01001, 2);

    // Asynchronous reset in the middle of a stall
    doReset();
    nxt(); setId(1, 0, 0, 2'b00, 1, 5, 1);  push(1, "rms.lw", 0, -1, -1, -1, 0);
    nxt(); setId(1, 5, 0, 2'b01, 1, 15, 0); push(1, "rms.st1", 1, -1, -1, -1, 0);
    nxt(); push(1, "rms.st2", 1, -1, -1, 5'b00010, 1);
                                            push(0, "rms.A0", 0, -1, -1, -1, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    push(1, "rms.B", 0, 0, 0, 0, 0);
    push(0, "rms.A", 0, 0, 0, 0, 0);
    ->chkNow;
    nxt(); reset = 1'b0; setId(0, 0, 0, 2'b00, 0, 0, 0);
    nxt();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core.
- Keeps its own shift-register scoreboard of in-flight destination tags, one slot per stage from EX onward, so it does not need every pipeline register routed into it.
- Each cycle it does two things for the instruction in ID:
  - computes a registered per-operand forward select, which the instruction carries into EX;
  - asserts a load-use stall when a producer's data cannot be ready in time.
- Generalises fixed EX/MEM and MEM/WB forwarding to DEPTH stages, NUM_SRC operands and a configurable load latency.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, number of post-EX producer slots that can forward (slot 1 = EX/MEM, slot 2 = MEM/WB, ...).
- LOAD_LAT, 2, first slot index at which load data is forwardable; legal range 1..DEPTH.
- CW, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- advance_en  in  1  global pipeline enable; when 0 all state holds.
- flush  in  1  kill the instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*AW  packed source register numbers, operand i at bits [i*AW +: AW].
- id_src_used  in  NUM_SRC  per-operand "actually read" mask.
- id_regwr  in  1  ID instruction writes a register.
- id_rd  in  AW  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- stall  out  1  hold PC and IF/ID, inject bubble into EX (combinational).
- ex_fwd_sel  out  NUM_SRC*SW  registered per-operand select for the EX instruction.
  - SW = $clog2(DEPTH+1).
  - 0 = register file; k = result held in slot k.
- slot_valid  out  DEPTH+1  debug: valid bit of slots 0..DEPTH (slot 0 = EX).
- stall_count  out  CW  saturating count of stall cycles.

Behaviour:
- Scoreboard: slots 0..DEPTH, each holding {valid, regwr, rd, is_load}. Slot 0 is the instruction in EX.
- Update rule when advance_en=1:
  - slot[k+1] <= slot[k] for k = 0..DEPTH-1; slot DEPTH drops off, and the register file is write-before-read.
  - slot[0] <= ID info if id_valid & ~flush & ~stall, otherwise a bubble (valid=0).
- When advance_en=0, the scoreboard, ex_fwd_sel and stall_count all hold.
- Match for ID operand i:
  - slot s (0..DEPTH-1) matches when id_src_used[i] & slot.valid & slot.regwr & slot.rd != 0 & slot.rd == src_i.
  - The youngest (lowest s) match wins; older matches are ignored.
- Next-cycle select for operand i: s+1 if a winning match exists, otherwise 0. Slot DEPTH is never matched, because it leaves the scoreboard at the same edge.
- Stall:
  - stall = id_valid & ~flush & (any operand whose winning slot s has is_load=1 and s+1 < LOAD_LAT).
  - A younger non-load match hides an older load, so no stall in that case.
  - Register 0 never matches and never stalls.
- ex_fwd_sel register:
  - When advance_en=1, loads the computed selects if ID advances (id_valid & ~flush & ~stall).
  - Otherwise (bubble, flush or invalid ID) loads all zeros.
- stall_count increments when stall & advance_en, and saturates at 2^CW-1.
- Simultaneous events:
  - flush forces stall=0 and a bubble.
  - stall with advance_en=0 leaves state unchanged while the stall output stays asserted.
- Reset, asynchronous, effective immediately:
  - all slot valid = 0;
  - ex_fwd_sel = 0;
  - stall_count = 0;
  - stall = 0, as a consequence of the empty scoreboard.
- Reset mid-stall: stall drops immediately and the scoreboard is empty.
- Latency: ex_fwd_sel is valid in the cycle the instruction occupies EX (one cycle after its ID cycle); stall has zero cycles of latency.

Test Plan:
- ALU back-to-back:
  - Stimulus: ID add rd=$8, then ID sub src0=$8.
  - Required: stall=0; in the cycle sub is in EX, ex_fwd_sel[0]=1.
- Distance-two ALU:
  - Stimulus: add $8; nop; then or src1=$8.
  - Required: ex_fwd_sel[1]=2 for or, and ex_fwd_sel[0]=0.
- Load-use with default LOAD_LAT=2:
  - Stimulus: lw $9; then ID add src0=$9.
  - Required: stall=1 for exactly one cycle and stall_count becomes 1; the next cycle stall=0, and when add is in EX, ex_fwd_sel[0]=2 and slot_valid[1]=0 (bubble).
- Priority and $0:
  - Stimulus: lw $9, then addi $9, then consumer of $9.
  - Required: stall=0 and sel=1.
  - Stimulus: a consumer of $0 behind a writer of $0.
  - Required: sel=0 and no stall.
- Flush and freeze:
  - Stimulus: flush=1 during a load-use hazard.
  - Required: stall=0; the EX slot becomes a bubble with ex_fwd_sel=0.
  - Stimulus: advance_en=0 for 3 cycles with stall asserted.
  - Required: slot_valid, ex_fwd_sel and stall_count are unchanged.
- Parameter sweep and reset:
  - Stimulus: DEPTH=4, LOAD_LAT=3, lw $5, then consumer.
  - Required: two stall cycles, then sel=3.
  - Stimulus: assert reset mid-stall, without a clock edge.
  - Required: stall, slot_valid and stall_count all go to 0.
